// File: rtl/tamper_response_ctrl.sv
// tamper_response_ctrl
// Fabric-side policy engine between the TAMPER macro event outputs and its
// response inputs. Each event is counted, classified by severity and turned
// into a response sequence.
//
// Ports
//   CLK, RESET_N              fabric clock, synchronous active-low reset
//   TAMPER_CHANGE_STROBE      event strobe; a held-high strobe is one event
//   DETECT_CATEGORY[3:0]      event category, reported on LAST_CATEGORY
//   DETECT_ATTEMPT/FAIL       counter increments for the event
//   MESH_SHORT_ERROR, CLK_ERROR, DIGEST_ERROR, POWERUP_DIGEST_ERROR,
//   SC_ROM_DIGEST_ERROR       severity flags
//   ARM                       1: responses enabled, 0: log only
//   SW_CLEAR                  release LOCKED and clear the counters
//   LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, TAMPER_RESET_N, ZEROIZE_N
//                             active-low responses, registered
//   ATTEMPT_CNT, FAIL_CNT     saturating 8-bit counters
//   LAST_CATEGORY             category of the most recent event
//   STATE                     0 IDLE, 1 RST_PULSE, 2 LOCKED, 3 ZEROIZE
//   EVENT_IRQ                 one-cycle pulse per captured event
//
// Timing: every input is registered once (stage 1). The capture edge follows
// that, and the response state/outputs change on the edge after the capture,
// i.e. two edges after the strobe is first sampled. SW_CLEAR runs through the
// same input stage, so a strobe and a SW_CLEAR driven in the same cycle meet
// at the capture edge, where the capture wins.
module tamper_response_ctrl #(
   parameter int ATTEMPT_RESET_THRESH = 4,
   parameter int FAIL_LOCK_THRESH     = 2,
   parameter int FAIL_ZEROIZE_THRESH  = 8,
   parameter int RESET_PULSE_CYCLES   = 16,
   parameter int ZEROIZE_ON_DIGEST    = 0
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       TAMPER_CHANGE_STROBE,
   input  logic [3:0] DETECT_CATEGORY,
   input  logic       DETECT_ATTEMPT,
   input  logic       DETECT_FAIL,
   input  logic       MESH_SHORT_ERROR,
   input  logic       CLK_ERROR,
   input  logic       DIGEST_ERROR,
   input  logic       POWERUP_DIGEST_ERROR,
   input  logic       SC_ROM_DIGEST_ERROR,
   input  logic       ARM,
   input  logic       SW_CLEAR,
   output logic       LOCKDOWN_ALL_N,
   output logic       DISABLE_ALL_IOS_N,
   output logic       TAMPER_RESET_N,
   output logic       ZEROIZE_N,
   output logic [7:0] ATTEMPT_CNT,
   output logic [7:0] FAIL_CNT,
   output logic [3:0] LAST_CATEGORY,
   output logic [2:0] STATE,
   output logic       EVENT_IRQ
);

   // Encoding order equals escalation priority, so "upward only" is a compare.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RST  = 3'd1;
   localparam logic [2:0] S_LOCK = 3'd2;
   localparam logic [2:0] S_ZERO = 3'd3;

   localparam logic [7:0] ATT_RST_T  = 8'(ATTEMPT_RESET_THRESH);
   localparam logic [7:0] FAIL_LCK_T = 8'(FAIL_LOCK_THRESH);
   localparam logic [7:0] FAIL_ZER_T = 8'(FAIL_ZEROIZE_THRESH);
   localparam logic [7:0] PULSE_LOAD = 8'(RESET_PULSE_CYCLES - 1);
   localparam bit         ZOD_EN     = (ZEROIZE_ON_DIGEST != 0);

   // Stage-1 input registers. flags_q: [6] attempt [5] fail [4] mesh
   // [3] clk [2] digest [1] powerup digest [0] sc rom digest
   logic       strobe_q, strobe_prev, arm_q, sw_clear_q;
   logic [3:0] cat_q;
   logic [6:0] flags_q;

   // Flags and ARM as seen at the capture edge, used for classification.
   logic [4:0] evt_flags;
   logic       evt_arm;

   logic [7:0] pulse_cnt, pulse_next;
   logic [7:0] att_base, att_next, fail_base, fail_next;
   logic [2:0] target, state_next;
   logic       capture, zero_hit, lock_hit, rst_hit, escalate, sw_release, rst_exit;

   assign capture = strobe_q & ~strobe_prev;

   // Counters are already post-increment here: classification happens the
   // cycle after capture, which is when EVENT_IRQ is high.
   always_comb begin
      zero_hit = evt_flags[4] | evt_flags[0] | (evt_flags[2] & ZOD_EN) | (FAIL_CNT >= FAIL_ZER_T);
      lock_hit = evt_flags[3] | evt_flags[2] | evt_flags[1] | (FAIL_CNT >= FAIL_LCK_T);
      rst_hit  = (ATTEMPT_CNT >= ATT_RST_T);
      target   = S_IDLE;
      if (evt_arm) begin
         if (zero_hit)      target = S_ZERO;
         else if (lock_hit) target = S_LOCK;
         else if (rst_hit)  target = S_RST;
      end
   end

   always_comb begin
      escalate   = EVENT_IRQ && (target > STATE);
      state_next = STATE;
      case (STATE)
         S_IDLE: if (escalate) state_next = target;
         S_RST: begin
            if (escalate)            state_next = target;
            else if (pulse_cnt == 0) state_next = S_IDLE;
         end
         S_LOCK: begin
            // Release only while the persistent fault flags are clear.
            if (escalate)
               state_next = target;
            else if (sw_clear_q && !capture && !flags_q[3] && !flags_q[2] && !flags_q[1])
               state_next = S_IDLE;
         end
         S_ZERO:  state_next = S_ZERO;
         default: state_next = S_IDLE;
      endcase

      sw_release = (STATE == S_LOCK) && (state_next == S_IDLE);
      rst_exit   = (STATE == S_RST)  && (state_next == S_IDLE);

      pulse_next = pulse_cnt;
      if (state_next == S_RST && STATE != S_RST) pulse_next = PULSE_LOAD;
      else if (STATE == S_RST && pulse_cnt != 0) pulse_next = pulse_cnt - 8'd1;

      // Clears apply first so a capture on the same edge still counts.
      att_base  = (rst_exit || sw_release) ? 8'd0 : ATTEMPT_CNT;
      fail_base = sw_release ? 8'd0 : FAIL_CNT;
      att_next  = att_base;
      fail_next = fail_base;
      if (capture && flags_q[6] && att_base  != 8'hFF) att_next  = att_base  + 8'd1;
      if (capture && flags_q[5] && fail_base != 8'hFF) fail_next = fail_base + 8'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         strobe_q          <= 1'b0;
         strobe_prev       <= 1'b0;
         arm_q             <= 1'b0;
         sw_clear_q        <= 1'b0;
         cat_q             <= 4'd0;
         flags_q           <= 7'd0;
         evt_flags         <= 5'd0;
         evt_arm           <= 1'b0;
         pulse_cnt         <= 8'd0;
         ATTEMPT_CNT       <= 8'd0;
         FAIL_CNT          <= 8'd0;
         LAST_CATEGORY     <= 4'd0;
         STATE             <= S_IDLE;
         EVENT_IRQ         <= 1'b0;
         LOCKDOWN_ALL_N    <= 1'b1;
         DISABLE_ALL_IOS_N <= 1'b1;
         TAMPER_RESET_N    <= 1'b1;
         ZEROIZE_N         <= 1'b1;
      end else begin
         strobe_q    <= TAMPER_CHANGE_STROBE;
         strobe_prev <= strobe_q;
         arm_q       <= ARM;
         sw_clear_q  <= SW_CLEAR;
         cat_q       <= DETECT_CATEGORY;
         flags_q     <= {DETECT_ATTEMPT, DETECT_FAIL, MESH_SHORT_ERROR, CLK_ERROR,
                         DIGEST_ERROR, POWERUP_DIGEST_ERROR, SC_ROM_DIGEST_ERROR};
         EVENT_IRQ   <= capture;
         if (capture) begin
            LAST_CATEGORY <= cat_q;
            evt_flags     <= flags_q[4:0];
            evt_arm       <= arm_q;
         end
         ATTEMPT_CNT       <= att_next;
         FAIL_CNT          <= fail_next;
         pulse_cnt         <= pulse_next;
         STATE             <= state_next;
         LOCKDOWN_ALL_N    <= !(state_next == S_LOCK || state_next == S_ZERO);
         DISABLE_ALL_IOS_N <= !(state_next == S_LOCK || state_next == S_ZERO);
         TAMPER_RESET_N    <= (state_next != S_RST);
         ZEROIZE_N         <= (state_next != S_ZERO);
      end
   end

endmodule

// File: tb/tb_tamper_response_ctrl.sv
// Directed testbench for tamper_response_ctrl. Two instances share all inputs:
// u_dut is the default build, u_dut_z is built with ZEROIZE_ON_DIGEST=1.
// Inputs are driven just after the falling edge, outputs are checked on the
// falling edge.
module tb_tamper_response_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       TAMPER_CHANGE_STROBE = 1'b0;
   logic [3:0] DETECT_CATEGORY = 4'd0;
   logic       DETECT_ATTEMPT = 1'b0, DETECT_FAIL = 1'b0, MESH_SHORT_ERROR = 1'b0;
   logic       CLK_ERROR = 1'b0, DIGEST_ERROR = 1'b0, POWERUP_DIGEST_ERROR = 1'b0;
   logic       SC_ROM_DIGEST_ERROR = 1'b0, ARM = 1'b0, SW_CLEAR = 1'b0;

   logic       lockdown_n, disable_n, treset_n, zeroize_n, irq;
   logic [7:0] attempt_cnt, fail_cnt;
   logic [3:0] last_cat;
   logic [2:0] state;

   logic       z_lockdown_n, z_disable_n, z_treset_n, z_zeroize_n, z_irq;
   logic [7:0] z_attempt_cnt, z_fail_cnt;
   logic [3:0] z_last_cat;
   logic [2:0] z_state;

   int n_vec = 0;
   int n_err = 0;
   int irq_total = 0;

   tamper_response_ctrl u_dut (
      .CLK(CLK), .RESET_N(RESET_N), .TAMPER_CHANGE_STROBE(TAMPER_CHANGE_STROBE),
      .DETECT_CATEGORY(DETECT_CATEGORY), .DETECT_ATTEMPT(DETECT_ATTEMPT),
      .DETECT_FAIL(DETECT_FAIL), .MESH_SHORT_ERROR(MESH_SHORT_ERROR),
      .CLK_ERROR(CLK_ERROR), .DIGEST_ERROR(DIGEST_ERROR),
      .POWERUP_DIGEST_ERROR(POWERUP_DIGEST_ERROR), .SC_ROM_DIGEST_ERROR(SC_ROM_DIGEST_ERROR),
      .ARM(ARM), .SW_CLEAR(SW_CLEAR),
      .LOCKDOWN_ALL_N(lockdown_n), .DISABLE_ALL_IOS_N(disable_n),
      .TAMPER_RESET_N(treset_n), .ZEROIZE_N(zeroize_n),
      .ATTEMPT_CNT(attempt_cnt), .FAIL_CNT(fail_cnt), .LAST_CATEGORY(last_cat),
      .STATE(state), .EVENT_IRQ(irq)
   );

   tamper_response_ctrl #(.ZEROIZE_ON_DIGEST(1)) u_dut_z (
      .CLK(CLK), .RESET_N(RESET_N), .TAMPER_CHANGE_STROBE(TAMPER_CHANGE_STROBE),
      .DETECT_CATEGORY(DETECT_CATEGORY), .DETECT_ATTEMPT(DETECT_ATTEMPT),
      .DETECT_FAIL(DETECT_FAIL), .MESH_SHORT_ERROR(MESH_SHORT_ERROR),
      .CLK_ERROR(CLK_ERROR), .DIGEST_ERROR(DIGEST_ERROR),
      .POWERUP_DIGEST_ERROR(POWERUP_DIGEST_ERROR), .SC_ROM_DIGEST_ERROR(SC_ROM_DIGEST_ERROR),
      .ARM(ARM), .SW_CLEAR(SW_CLEAR),
      .LOCKDOWN_ALL_N(z_lockdown_n), .DISABLE_ALL_IOS_N(z_disable_n),
      .TAMPER_RESET_N(z_treset_n), .ZEROIZE_N(z_zeroize_n),
      .ATTEMPT_CNT(z_attempt_cnt), .FAIL_CNT(z_fail_cnt), .LAST_CATEGORY(z_last_cat),
      .STATE(z_state), .EVENT_IRQ(z_irq)
   );

   // Clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // IRQ pulse monitor for the default build
   always @(negedge CLK) if (irq === 1'b1) irq_total++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic sw_clear_pulse();
      SW_CLEAR = 1'b1;
      @(negedge CLK);
      SW_CLEAR = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   // One-cycle strobe with its event flags. Returns at the falling edge after
   // the response edge (capture edge + 1). CLK/DIGEST/POWERUP flags are left
   // as set because they model persistent status.
   task automatic strobe_evt(input logic [3:0] cat, input logic att, input logic fl,
                             input logic mesh, input logic ce, input logic dg,
                             input logic pu, input logic sc);
      DETECT_CATEGORY = cat; DETECT_ATTEMPT = att; DETECT_FAIL = fl;
      MESH_SHORT_ERROR = mesh; CLK_ERROR = ce; DIGEST_ERROR = dg;
      POWERUP_DIGEST_ERROR = pu; SC_ROM_DIGEST_ERROR = sc;
      TAMPER_CHANGE_STROBE = 1'b1;
      @(negedge CLK);
      TAMPER_CHANGE_STROBE = 1'b0;
      DETECT_ATTEMPT = 1'b0; DETECT_FAIL = 1'b0;
      MESH_SHORT_ERROR = 1'b0; SC_ROM_DIGEST_ERROR = 1'b0;
      @(negedge CLK);
      chk("event_irq_pulse", {31'd0, irq}, 32'd1);
      @(negedge CLK);
   endtask

   initial begin
      int lo_cycles;
      int irq_start;
      bit done;

      // Reset values
      @(negedge CLK);
      do_reset();
      chk("rst_outs_n", {28'd0, lockdown_n, disable_n, treset_n, zeroize_n}, 32'hF);
      chk("rst_attempt", {24'd0, attempt_cnt}, 32'd0);
      chk("rst_fail", {24'd0, fail_cnt}, 32'd0);
      chk("rst_state_cat_irq", {24'd0, state, last_cat, irq}, 32'd0);

      // Four attempts -> 16-clock reset pulse
      ARM = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         strobe_evt(4'(i), 1, 0, 0, 0, 0, 0, 0);
         chk("attempt_count", {24'd0, attempt_cnt}, i);
         chk("attempt_state_idle", {29'd0, state}, 32'd0);
      end
      strobe_evt(4'hA, 1, 0, 0, 0, 0, 0, 0);
      chk("rst_pulse_state", {29'd0, state}, 32'd1);
      chk("rst_pulse_low", {31'd0, treset_n}, 32'd0);
      chk("irq_one_cycle", {31'd0, irq}, 32'd0);
      chk("attempt_4", {24'd0, attempt_cnt}, 32'd4);
      lo_cycles = 1;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge CLK);
         if (treset_n === 1'b0) lo_cycles++;
         else done = 1'b1;
      end
      chk("rst_pulse_width", lo_cycles, 32'd16);
      chk("rst_exit_state", {29'd0, state}, 32'd0);
      chk("rst_exit_attempt_clr", {24'd0, attempt_cnt}, 32'd0);
      chk("last_category", {28'd0, last_cat}, 32'hA);

      // CLK_ERROR -> LOCKED, SW_CLEAR gated by persistent flags
      strobe_evt(4'h3, 0, 1, 0, 1, 0, 0, 0);
      chk("lock_state", {29'd0, state}, 32'd2);
      chk("lock_outs_n", {28'd0, lockdown_n, disable_n, treset_n, zeroize_n}, 32'h3);
      chk("lock_fail_cnt", {24'd0, fail_cnt}, 32'd1);
      sw_clear_pulse();
      @(negedge CLK);
      chk("clear_blocked_by_clk_err", {29'd0, state}, 32'd2);
      CLK_ERROR = 1'b0;
      @(negedge CLK);
      sw_clear_pulse();
      chk("clear_state", {29'd0, state}, 32'd0);
      chk("clear_counters", {16'd0, attempt_cnt, fail_cnt}, 32'd0);
      chk("clear_outs_n", {28'd0, lockdown_n, disable_n, treset_n, zeroize_n}, 32'hF);

      // Strobe and SW_CLEAR in the same cycle while LOCKED: capture wins
      strobe_evt(4'h5, 0, 0, 0, 1, 0, 0, 0);
      CLK_ERROR = 1'b0;
      @(negedge CLK);
      DETECT_ATTEMPT = 1'b1;
      TAMPER_CHANGE_STROBE = 1'b1;
      SW_CLEAR = 1'b1;
      @(negedge CLK);
      DETECT_ATTEMPT = 1'b0;
      TAMPER_CHANGE_STROBE = 1'b0;
      SW_CLEAR = 1'b0;
      repeat (4) @(negedge CLK);
      chk("strobe_clear_same_cycle", {29'd0, state}, 32'd2);
      chk("strobe_clear_attempt", {24'd0, attempt_cnt}, 32'd1);
      sw_clear_pulse();
      chk("second_clear_state", {29'd0, state}, 32'd0);

      // Strobe held high for 10 cycles is a single event
      irq_start = irq_total;
      DETECT_ATTEMPT = 1'b1;
      TAMPER_CHANGE_STROBE = 1'b1;
      repeat (10) @(negedge CLK);
      TAMPER_CHANGE_STROBE = 1'b0;
      DETECT_ATTEMPT = 1'b0;
      repeat (4) @(negedge CLK);
      chk("held_strobe_irqs", irq_total - irq_start, 32'd1);
      chk("held_strobe_attempt", {24'd0, attempt_cnt}, 32'd1);

      // RST_PULSE preempted by MESH_SHORT -> ZEROIZE, terminal until RESET_N
      for (int i = 0; i < 3; i++) strobe_evt(4'h1, 1, 0, 0, 0, 0, 0, 0);
      chk("preempt_rst_state", {29'd0, state}, 32'd1);
      @(negedge CLK);
      strobe_evt(4'h7, 0, 0, 1, 0, 0, 0, 0);
      chk("zeroize_state", {29'd0, state}, 32'd3);
      chk("zeroize_outs_n", {28'd0, lockdown_n, disable_n, treset_n, zeroize_n}, 32'h2);
      chk("zeroize_attempt_kept", {24'd0, attempt_cnt}, 32'd4);
      sw_clear_pulse();
      chk("zeroize_ignores_clear", {29'd0, state}, 32'd3);
      strobe_evt(4'h8, 1, 0, 0, 0, 0, 0, 0);
      chk("zeroize_counts", {24'd0, attempt_cnt}, 32'd5);
      RESET_N = 1'b0;
      @(negedge CLK);
      chk("midseq_reset_state", {29'd0, state}, 32'd0);
      chk("midseq_reset_outs_n", {28'd0, lockdown_n, disable_n, treset_n, zeroize_n}, 32'hF);
      chk("midseq_reset_counters", {16'd0, attempt_cnt, fail_cnt}, 32'd0);
      RESET_N = 1'b1;
      @(negedge CLK);

      // ARM=0: 300 fail events saturate FAIL_CNT, no response
      ARM = 1'b0;
      irq_start = irq_total;
      for (int i = 0; i < 300; i++) strobe_evt(4'h2, 0, 1, 0, 0, 0, 0, 0);
      chk("fail_saturate", {24'd0, fail_cnt}, 32'd255);
      chk("disarmed_state", {29'd0, state}, 32'd0);
      chk("disarmed_irqs", irq_total - irq_start, 32'd300);
      chk("disarmed_outs_n", {28'd0, lockdown_n, disable_n, treset_n, zeroize_n}, 32'hF);

      // Fail lock threshold boundary
      do_reset();
      ARM = 1'b1;
      strobe_evt(4'h4, 0, 1, 0, 0, 0, 0, 0);
      chk("fail1_below_lock", {29'd0, state}, 32'd0);
      strobe_evt(4'h4, 0, 1, 0, 0, 0, 0, 0);
      chk("fail2_lock", {29'd0, state}, 32'd2);

      // DIGEST_ERROR classification in both builds
      do_reset();
      ARM = 1'b1;
      strobe_evt(4'h9, 0, 0, 0, 0, 1, 0, 0);
      DIGEST_ERROR = 1'b0;
      chk("digest_default_lock", {29'd0, state}, 32'd2);
      chk("digest_zod_zeroize", {29'd0, z_state}, 32'd3);
      chk("digest_zod_zeroize_n", {31'd0, z_zeroize_n}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
